// File: rtl/uart_tx_core_if.sv
// ---------------------------------------------------------------------------
// uart_tx_core_if
//
// Purpose:
//   Bundles the byte-request handshake and the serial line of the UART
//   transmitter so the requester and the core share one connection.
//
// Signals:
//   tx_en    requester -> core   transmit request, level-sensitive
//   tx_data  requester -> core   byte to send, latched when accepted
//   tx       core -> requester   serial line, idle high
//   tx_busy  core -> requester   high while a frame is in flight
//   tx_done  core -> requester   one-cycle pulse when the frame completes
//
// Modports:
//   master   the side issuing requests (echo/test logic, log senders)
//   slave    the transmitter core
// ---------------------------------------------------------------------------
interface uart_tx_core_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_en,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_en,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//
// Purpose:
//   Standalone UART transmitter. Each accepted request sends one byte as
//   start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop
//   bits. The core has its own baud timer, so it needs no shared uart
//   wrapper.
//
// Parameters:
//   CLK_FREQ   sys_clk frequency in Hz
//   BAUD       line rate in bit/s; CLK_FREQ/BAUD sys_clk cycles per bit (>= 2)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   sys_clk    system clock, rising edge
//   rst        asynchronous active-high reset; abandons any frame in flight
//   bus        uart_tx_core_if slave modport (tx_en, tx_data, tx, tx_busy,
//              tx_done)
// ---------------------------------------------------------------------------
module uart_tx_core #(
    parameter int CLK_FREQ  = 30000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic           sys_clk,
    input  logic           rst,
    uart_tx_core_if.slave  bus
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int TIMER_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(DIVISOR - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    // The last cycle of every bit time; all state and line changes happen here.
    assign bit_end = (timer_q == TIMER_MAX);

    // State register. The line is a flop so it never glitches during
    // state changes, and reset forces it idle-high immediately.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic. The value for the next bit is loaded into tx_q on the
    // edge that ends the current bit, so tx changes exactly at bit boundaries.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (state_q != S_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TIMER_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                timer_d = '0;
                if (bus.tx_en) begin
                    shift_d    = bus.tx_data;
                    parity_d   = (PARITY == 1) ? ~(^bus.tx_data) : (^bus.tx_data);
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY != 0) begin
                            tx_d    = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        // Shift right so the next data bit is always at bit 1.
                        tx_d      = shift_q[1];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core
//
// Purpose:
//   Drives five transmitter instances (different divisor / parity / stop-bit
//   settings) from one shared request stream and compares every output,
//   every cycle, with a frame-level reference model that expands each
//   accepted byte into its expected per-cycle line waveform.
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int NUM = 5;
    localparam int CFS   [NUM] = '{16, 16, 16, 16, 2};
    localparam int PARS  [NUM] = '{0, 2, 1, 0, 0};
    localparam int STOPS [NUM] = '{1, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       txEn = 1'b0;
    logic [7:0] txData = 8'h00;

    int checkCount = 0;
    int passCount  = 0;

    event doFinal;

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    // Present one request for holdCycles cycles, then leave the line idle for
    // gapCycles cycles, occasionally scrambling tx_data while idle.
    task automatic applyStimulus(input logic [7:0] data, input int holdCycles, input int gapCycles);
        @(negedge clk);
        txData = data;
        txEn   = 1'b1;
        repeat (holdCycles) @(negedge clk);
        txEn = 1'b0;
        for (int i = 0; i < gapCycles; i++) begin
            if ($urandom_range(15) == 0) txData = 8'($urandom);
            @(negedge clk);
        end
    endtask

    genvar g;
    for (g = 0; g < NUM; g++) begin : inst
        localparam int DIV = CFS[g];
        localparam int PAR = PARS[g];
        localparam int STB = STOPS[g];

        uart_tx_core_if bus ();
        assign bus.tx_en   = txEn;
        assign bus.tx_data = txData;

        uart_tx_core #(
            .CLK_FREQ (CFS[g]),
            .BAUD     (1),
            .PARITY   (PAR),
            .STOP_BITS(STB)
        ) dut (
            .sys_clk(clk),
            .rst    (rst),
            .bus    (bus)
        );

        logic expFrame[$];
        int   pos = -1;
        logic expTx = 1'b1;
        logic expBusy = 1'b0;
        logic expDone = 1'b0;
        int   modelFrames = 0;
        int   seenDone = 0;

        // Reference model: on acceptance, build the whole frame as a list of
        // bit values, stretch each to DIV cycles, then replay one per cycle.
        // A new request is only considered once the previous frame has ended.
        initial forever begin
            @(posedge clk or posedge rst);
            expDone = 1'b0;
            if (rst) begin
                pos     = -1;
                expTx   = 1'b1;
                expBusy = 1'b0;
            end else if (pos >= 0) begin
                pos++;
                if (pos == expFrame.size()) begin
                    pos     = -1;
                    expTx   = 1'b1;
                    expBusy = 1'b0;
                    expDone = 1'b1;
                    modelFrames++;
                end else begin
                    expTx = expFrame[pos];
                end
            end else if (txEn) begin
                logic bitsList[$];
                int   ones;
                bitsList = {};
                bitsList.push_back(1'b0);
                for (int i = 0; i < 8; i++) bitsList.push_back(txData[i]);
                ones = $countones(txData);
                if (PAR == 1) bitsList.push_back((ones % 2) == 0);
                if (PAR == 2) bitsList.push_back((ones % 2) == 1);
                for (int s = 0; s < STB; s++) bitsList.push_back(1'b1);
                expFrame = {};
                foreach (bitsList[k]) begin
                    for (int c = 0; c < DIV; c++) expFrame.push_back(bitsList[k]);
                end
                pos     = 0;
                expTx   = expFrame[0];
                expBusy = 1'b1;
            end
        end

        // Per-cycle comparison, sampled on the falling edge.
        always @(negedge clk) begin
            if (!rst) begin
                checkOutput($sformatf("i%0d.tx", g), 32'(bus.tx), 32'(expTx));
                checkOutput($sformatf("i%0d.busy", g), 32'(bus.tx_busy), 32'(expBusy));
                checkOutput($sformatf("i%0d.done", g), 32'(bus.tx_done), 32'(expDone));
                if (bus.tx_done === 1'b1) seenDone++;
            end
        end

        // Reset must take effect without waiting for a clock edge.
        always @(posedge rst) begin
            #1;
            checkOutput($sformatf("i%0d.rst_tx", g), 32'(bus.tx), 32'd1);
            checkOutput($sformatf("i%0d.rst_busy", g), 32'(bus.tx_busy), 32'd0);
            checkOutput($sformatf("i%0d.rst_done", g), 32'(bus.tx_done), 32'd0);
        end

        // Total completed frames must agree with the model at the end.
        always @(doFinal) begin
            checkOutput($sformatf("i%0d.frames", g), 32'(seenDone), 32'(modelFrames));
        end
    end

    // Main sequence: reset, directed frames, held request with data change,
    // mid-frame reset, then randomized requests.
    initial begin
        #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] directed frames");
        applyStimulus(8'h55, 1, 200);
        applyStimulus(8'hA5, 1, 200);
        applyStimulus(8'h00, 1, 200);
        applyStimulus(8'hFF, 1, 200);

        $display("[TB] held request with data change mid-frame");
        @(negedge clk);
        txData = 8'h41;
        txEn   = 1'b1;
        repeat (50) @(negedge clk);
        txData = 8'h42;
        repeat (400) @(negedge clk);
        txEn = 1'b0;
        repeat (200) @(negedge clk);

        $display("[TB] reset during data bit 3");
        @(negedge clk);
        txData = 8'h0F;
        txEn   = 1'b1;
        @(negedge clk);
        txEn = 1'b0;
        repeat (16 * 4 + 7) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(8'h0F, 1, 200);

        $display("[TB] randomized requests");
        for (int n = 0; n < 25; n++) begin
            applyStimulus(8'($urandom), $urandom_range(3, 1), $urandom_range(200, 0));
        end
        repeat (200) @(negedge clk);

        ->doFinal;
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Standalone UART transmitter that serialises one byte per request into an 8-bit asynchronous frame with optional parity. It is the transmit end of the board's serial link. It reuses the tx_en/tx_busy handshake already used by the echo/test logic, so that logic can drive it directly. It owns its own baud timer, which lets it run without the shared uart wrapper, for example in log/status senders.

Parameters:
CLK_FREQ, 30000000, sys_clk frequency in Hz
BAUD, 115200, line rate in bit/s
DIVISOR, CLK_FREQ/BAUD (integer, truncated; 260 at defaults), sys_clk cycles per bit; must be >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
sys_clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
tx_en  input  1  transmit request, level-sensitive, sampled only in IDLE
tx_data  input  8  byte to send; latched on the accepting edge
tx  output  1  serial line, idle high, registered
tx_busy  output  1  high from the accepting edge until the frame ends
tx_done  output  1  one-cycle pulse on the edge the last stop bit completes

Behaviour:
- Reset (async, any state, including mid-frame):
  - tx=1, tx_busy=0, tx_done=0, state=IDLE.
  - Bit timer and bit index are cleared.
  - Any partial frame is abandoned; no completion pulse.
- States: IDLE -> START -> DATA -> PARITY (only when PARITY != 0) -> STOP -> IDLE.
- IDLE:
  - tx=1, tx_busy=0.
  - On an edge with tx_en=1: latch tx_data into a shift register, compute the parity bit from the latched byte, go to START.
  - On that same edge tx goes 0 and tx_busy goes 1, giving zero-cycle latency after the accepting edge.
- Bit timing:
  - The timer counts 0..DIVISOR-1.
  - Each bit occupies exactly DIVISOR sys_clk cycles.
  - State and bit changes happen on the edge where timer = DIVISOR-1; the timer wraps to 0 on that edge.
- START: tx=0 for one bit time.
- DATA:
  - 8 bits, LSB first; the bit index counts 0..7.
  - Leave DATA after bit 7.
- PARITY:
  - Odd: the bit is set so the total count of ones across the 8 data bits plus parity is odd.
  - Even: that total is even.
- STOP:
  - tx=1 for STOP_BITS bit times.
  - On the final edge: state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Frame length from the accepting edge to tx_busy falling = DIVISOR*(10 + (PARITY!=0) + (STOP_BITS-1)) cycles.
- Back-to-back frames:
  - The earliest next acceptance is the edge after tx_busy falls.
  - So at least one full sys_clk of idle-high tx separates frames.
  - With tx_en held high continuously, frames repeat with exactly that 1-cycle gap.
- Ignored while busy:
  - tx_en is ignored; held or pulsed requests are not queued.
  - Changes on tx_data have no effect on the frame in flight.
- tx_done and tx_busy are never high in IDLE-after-reset without a frame having completed.
- The glitch-free tx requirement means tx is driven from a flop, never decoded combinationally from state.

Test Plan:
- Sim params CLK_FREQ=16, BAUD=1 (DIVISOR=16), PARITY=0, STOP_BITS=1; pulse tx_en 1 cycle with tx_data=0x55 -> tx sequence per 16-cycle bit: 0,1,0,1,0,1,0,1,0,1. tx_busy high exactly 160 cycles. One tx_done pulse coincident with tx_busy falling.
- PARITY=2, tx_data=0xA5 -> parity bit 0, frame 176 cycles. PARITY=1, same data -> parity bit 1.
- STOP_BITS=2, PARITY=0, tx_data=0x00 -> start bit plus 8 zeros (144 cycles low), then 32 cycles high. Frame 176 cycles, tx_done at cycle 176.
- tx_en held high, tx_data=0x41 then changed to 0x42 mid-frame -> first frame carries 0x41. Second frame starts 1 cycle after tx_busy falls and carries 0x42. Extra tx_en cycles during busy produce no additional frames.
- Assert rst for 1 cycle mid DATA bit 3 -> tx=1 and tx_busy=0 immediately (before next clock edge), no tx_done. Next tx_en=1 with 0x0F sends a complete, correct frame.
- DIVISOR=2 (CLK_FREQ=2, BAUD=1), 0xFF -> each bit exactly 2 cycles, frame 20 cycles, no off-by-one at minimum divisor.
